// File: rtl/overflow_range_store.sv
// rtl/overflow_range_store.sv - circular store of inclusive overflow ranges with a same-cycle hit query
// Defining OM_MERGE_EN widens an overlapping/adjacent entry instead of allocating a new one.
module overflow_range_store #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 32
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     clr_i,
   input  logic                     wr_en_i,
   input  logic [ADDR_W-1:0]        wr_first_i,
   input  logic [ADDR_W-1:0]        wr_last_i,
   input  logic [ADDR_W-1:0]        find_addr_i,
   output logic                     hit_o,
   output logic [$clog2(DEPTH)-1:0] hit_idx_o,
   input  logic [$clog2(DEPTH)-1:0] rd_idx_i,
   output logic [ADDR_W-1:0]        rd_first_o,
   output logic [ADDR_W-1:0]        rd_last_o,
   output logic                     rd_valid_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     full_o,
   output logic                     overwrite_o,
   output logic                     bad_wr_o
);

   localparam int IW  = $clog2(DEPTH);
   localparam int CW  = IW + 1;
   localparam int AXW = ADDR_W + 1;

   logic [ADDR_W-1:0] first_q [DEPTH];
   logic [ADDR_W-1:0] last_q  [DEPTH];
   logic [DEPTH-1:0]  valid_q;
   logic [IW-1:0]     wptr_q;
   logic [CW-1:0]     count_q;

   logic [DEPTH-1:0]  hit_vec;
   logic              bad_wr;
   logic              wr_ok;

   logic              merge_hit;
   logic [IW-1:0]     merge_idx;
   logic [ADDR_W-1:0] merge_first;
   logic [ADDR_W-1:0] merge_last;

   // Query sees pre-write contents; new ranges appear the cycle after the strobe.
   always_comb begin
      hit_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         hit_vec[i] = valid_q[i] && (find_addr_i >= first_q[i]) && (find_addr_i <= last_q[i]);
      end
   end

   always_comb begin
      hit_idx_o = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (hit_vec[i]) hit_idx_o = IW'(i);
      end
   end

   assign hit_o = |hit_vec;

   assign bad_wr = wr_en_i && (wr_first_i > wr_last_i);
   assign wr_ok  = wr_en_i && !bad_wr;

`ifdef OM_MERGE_EN
   logic [DEPTH-1:0] cand_vec;
   logic [AXW-1:0]   new_first_x;
   logic [AXW-1:0]   new_last_p1;

   // Extra top bit keeps last+1 of an all-ones range from wrapping to zero.
   assign new_first_x = {1'b0, wr_first_i};
   assign new_last_p1 = {1'b0, wr_last_i} + AXW'(1);

   always_comb begin
      cand_vec = '0;
      for (int i = 0; i < DEPTH; i++) begin
         cand_vec[i] = valid_q[i]
                    && (new_first_x <= ({1'b0, last_q[i]} + AXW'(1)))
                    && ({1'b0, first_q[i]} <= new_last_p1);
      end
   end

   always_comb begin
      merge_idx = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (cand_vec[i]) merge_idx = IW'(i);
      end
   end

   assign merge_hit   = |cand_vec;
   assign merge_first = (first_q[merge_idx] < wr_first_i) ? first_q[merge_idx] : wr_first_i;
   assign merge_last  = (last_q[merge_idx] > wr_last_i) ? last_q[merge_idx] : wr_last_i;
`else
   assign merge_hit   = 1'b0;
   assign merge_idx   = '0;
   assign merge_first = wr_first_i;
   assign merge_last  = wr_last_i;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q     <= '0;
         wptr_q      <= '0;
         count_q     <= '0;
         rd_first_o  <= '0;
         rd_last_o   <= '0;
         rd_valid_o  <= 1'b0;
         overwrite_o <= 1'b0;
         bad_wr_o    <= 1'b0;
      end else begin
         rd_first_o  <= first_q[rd_idx_i];
         rd_last_o   <= last_q[rd_idx_i];
         rd_valid_o  <= valid_q[rd_idx_i];
         overwrite_o <= 1'b0;
         bad_wr_o    <= 1'b0;
         if (clr_i) begin
            valid_q <= '0;
            wptr_q  <= '0;
            count_q <= '0;
         end else if (bad_wr) begin
            bad_wr_o <= 1'b1;
         end else if (wr_ok) begin
            if (merge_hit) begin
               first_q[merge_idx] <= merge_first;
               last_q[merge_idx]  <= merge_last;
            end else begin
               // Circular pointer: a valid slot here is always the oldest range.
               first_q[wptr_q] <= wr_first_i;
               last_q[wptr_q]  <= wr_last_i;
               valid_q[wptr_q] <= 1'b1;
               wptr_q          <= wptr_q + IW'(1);
               if (valid_q[wptr_q]) overwrite_o <= 1'b1;
               else                 count_q     <= count_q + CW'(1);
            end
         end
      end
   end

   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: doc/overflow_range_store.md
Name: overflow_range_store

Overview:
- Responder end of the overflow-tracking path. Stores the completed heap-overflow ranges that the store-tracking unit emits, as inclusive [first, last] address pairs.
- Answers same-cycle "is this address inside any recorded range" queries for the load/JALR check logic.
- Circular replacement: when full, the oldest range is overwritten. Sits beside the tracker in the execute stage.

Parameters:
- DEPTH, 8, number of range entries; power of two, minimum 2
- ADDR_W, 32, address width of ranges and queries

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- clr_i  in  1  synchronous clear of all entries (software/debug flush)
- wr_en_i  in  1  single-cycle write strobe from tracker
- wr_first_i  in  ADDR_W  first byte address of range, inclusive
- wr_last_i  in  ADDR_W  last byte address of range, inclusive
- find_addr_i  in  ADDR_W  query address
- hit_o  out  1  combinational: find_addr_i lies inside some valid entry
- hit_idx_o  out  $clog2(DEPTH)  lowest index of a hitting entry; 0 when no hit
- rd_idx_i  in  $clog2(DEPTH)  debug read index
- rd_first_o  out  ADDR_W  registered debug read of entry first
- rd_last_o  out  ADDR_W  registered debug read of entry last
- rd_valid_o  out  1  registered valid bit of the read entry
- count_o  out  $clog2(DEPTH)+1  number of valid entries
- full_o  out  1  count_o == DEPTH
- overwrite_o  out  1  registered pulse: last accepted write evicted a valid entry
- bad_wr_o  out  1  registered pulse: last write was dropped because first > last

Behaviour:
- Reset (rst_i=1): all valid bits 0, write pointer 0, count 0.
  - All registered outputs are 0: rd_*, overwrite_o, bad_wr_o.
  - hit_o is 0 by consequence of no valid entries.
- Storage per entry: first, last, valid. Write pointer wptr wraps modulo DEPTH.
- Query path (fully combinational):
  - An entry hits when valid && first <= find_addr_i <= last, compared unsigned and inclusive at both ends.
  - hit_o is the OR of all entry hits; hit_idx_o is a priority encode, lowest index first.
- Write acceptance: wr_en_i=1 with wr_first_i <= wr_last_i.
  - If wr_first_i > wr_last_i: no state change; bad_wr_o=1 in the next cycle.
- Allocation (merge disabled, or no merge candidate):
  - Write entry[wptr] = {first, last, valid=1}; wptr <= wptr+1 mod DEPTH.
  - If entry[wptr] was already valid: count unchanged and overwrite_o=1 next cycle. This is the oldest entry, because the pointer is circular.
  - Otherwise count <= count+1.
- Write/query same cycle: the query sees contents from before the write. A new range becomes visible to hit_o in the cycle after wr_en_i.
- Clear: clr_i=1 zeroes valid bits, wptr and count in the next cycle.
  - clr_i takes priority over a simultaneous wr_en_i; that write is discarded and no pulse is produced.
  - rst_i takes priority over everything.
- Debug read: rd_first_o, rd_last_o and rd_valid_o show entry[rd_idx_i] one cycle after rd_idx_i is presented, reflecting state after any write in the presenting cycle is excluded, i.e. pre-write contents.
- Pulse outputs are high for exactly one cycle per event.
- Width rules:
  - Adjacency arithmetic is done in ADDR_W+1 bits, so last = all-ones never wraps to 0.
  - count_o never exceeds DEPTH.

Optional Feature:
- Macro: OM_MERGE_EN
- With OM_MERGE_EN defined:
  - On an accepted write, scan the valid entries for a merge candidate.
  - A candidate overlaps or is adjacent to the new range: new.first <= e.last+1 && e.first <= new.last+1, computed in ADDR_W+1 bits.
  - The lowest-index candidate is widened to first=min(e.first,new.first) and last=max(e.last,new.last).
  - wptr, count and overwrite_o are unchanged by a merge. Only one entry merges per write; secondary overlaps are left as they are.
- Without OM_MERGE_EN: every accepted write allocates, and duplicate or overlapping entries are permitted.

Test Plan:
- Reset, then write [0x1000,0x1040]; next cycle query 0x1000, 0x1040, 0x1041, 0x0FFF -> hit_o = 1, 1, 0, 0; hit_idx_o=0; count_o=1.
- Write the range at cycle t, query its first address at cycle t -> hit_o=0; query at t+1 -> hit_o=1.
- DEPTH=8: write 9 disjoint ranges [0x100*k, 0x100*k+0x20] for k=1..9 -> after the 9th, full_o=1, count_o=8 and overwrite_o pulses once. Query 0x100 -> 0; query 0x900 -> 1 with hit_idx_o=0.
- Write [0x2040,0x2000] -> bad_wr_o pulses; count_o unchanged; query 0x2020 -> 0.
- With 3 entries valid, assert clr_i and wr_en_i [0x3000,0x3010] together -> next cycle count_o=0, hit_o=0 for 0x3000, no overwrite_o pulse.
- OM_MERGE_EN: write [0x4000,0x400F], then [0x4010,0x401F] -> count_o=1; debug read of idx 0 gives rd_first_o=0x4000, rd_last_o=0x401F. Without the macro -> count_o=2.
